axi_burst_checker: RTL

Parametrised AXI4 burst master that writes a programmable number of INCR bursts to memory, reads each one back and compares it against the expected pattern. It counts response and data errors. It is the runtime-configurable successor to the fixed single-burst write/read master and sits on an interconnect master port as a bring-up and memory self-test engine.

---
 rtl/axi_burst_checker.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/axi_burst_checker.sv
// axi_burst_checker: AXI4 INCR write/read-back memory self-test master.
// Writes address-pattern bursts, reads each back and counts response/data errors.
module axi_burst_checker #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [7:0]            i_burst_len,
    input  logic [15:0]           i_num_bursts,
    output logic                  o_done,
    output logic [ERR_WIDTH-1:0]  o_err_cnt,
    output logic [ADDR_WIDTH-1:0] o_awaddr,
    output logic [7:0]            o_awlen,
    output logic                  o_awvalid,
    input  logic                  i_awready,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_wlast,
    output logic                  o_wvalid,
    input  logic                  i_wready,
    input  logic [1:0]            i_bresp,
    input  logic                  i_bvalid,
    output logic                  o_bready,
    output logic [ADDR_WIDTH-1:0] o_araddr,
    output logic [7:0]            o_arlen,
    output logic                  o_arvalid,
    input  logic                  i_arready,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]            i_rresp,
    input  logic                  i_rlast,
    input  logic                  i_rvalid,
    output logic                  o_rready
);
    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, NEXT, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

    state_t                state;
    logic [7:0]            len, beat;
    logic [15:0]           num, k;
    logic [ADDR_WIDTH-1:0] burst_addr, beat_addr, stride;
    logic [ERR_WIDTH-1:0]  err, err_inc;
    logic                  r_bad;

    // beat_addr doubles as the write data and the expected read data
    assign stride    = ADDR_WIDTH'((32'(len) + 32'd1) * 32'(DATA_WIDTH / 8));
    assign err_inc   = (&err) ? err : err + 1'b1;
    assign r_bad     = i_rresp != 2'd0 || i_rdata != DATA_WIDTH'(beat_addr) || i_rlast != (beat == len);
    assign o_awaddr  = burst_addr;
    assign o_araddr  = burst_addr;
    assign o_awlen   = len;
    assign o_arlen   = len;
    assign o_wdata   = DATA_WIDTH'(beat_addr);
    assign o_err_cnt = err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            len        <= '0;
            beat       <= '0;
            num        <= '0;
            k          <= '0;
            burst_addr <= '0;
            beat_addr  <= '0;
            err        <= '0;
            o_done     <= 1'b0;
            o_awvalid  <= 1'b0;
            o_wvalid   <= 1'b0;
            o_wlast    <= 1'b0;
            o_bready   <= 1'b0;
            o_arvalid  <= 1'b0;
            o_rready   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: if (i_start) begin
                    len        <= i_burst_len;
                    num        <= i_num_bursts;
                    burst_addr <= i_base_addr;
                    beat_addr  <= i_base_addr;
                    k          <= '0;
                    err        <= '0;
                    if (i_num_bursts == 16'd0) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end else begin
                        state     <= AW;
                        o_awvalid <= 1'b1;
                    end
                end
                AW: if (i_awready) begin
                    o_awvalid <= 1'b0;
                    o_wvalid  <= 1'b1;
                    o_wlast   <= len == 8'd0;
                    beat      <= '0;
                    state     <= W;
                end
                W: if (i_wready) begin
                    beat      <= beat + 8'd1;
                    beat_addr <= beat_addr + STEP;
                    if (beat == len) begin
                        o_wvalid <= 1'b0;
                        o_wlast  <= 1'b0;
                        o_bready <= 1'b1;
                        state    <= B;
                    end else begin
                        o_wlast <= beat + 8'd1 == len;
                    end
                end
                B: if (i_bvalid) begin
                    if (i_bresp != 2'd0) err <= err_inc;
                    o_bready  <= 1'b0;
                    o_arvalid <= 1'b1;
                    beat_addr <= burst_addr;
                    state     <= AR;
                end
                AR: if (i_arready) begin
                    o_arvalid <= 1'b0;
                    o_rready  <= 1'b1;
                    beat      <= '0;
                    state     <= R;
                end
                R: if (i_rvalid) begin
                    if (r_bad) err <= err_inc;
                    beat      <= beat + 8'd1;
                    beat_addr <= beat_addr + STEP;
                    if (beat == len) begin
                        o_rready <= 1'b0;
                        state    <= NEXT;
                    end
                end
                NEXT: if (k == num - 16'd1) begin
                    state  <= DONE;
                    o_done <= 1'b1;
                end else begin
                    k          <= k + 16'd1;
                    burst_addr <= burst_addr + stride;
                    beat_addr  <= burst_addr + stride;
                    o_awvalid  <= 1'b1;
                    state      <= AW;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
